// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFObuffer read-side drain controller.
package fifo_drain_pkg;

  localparam int DRAIN_DATA_W     = 32;
  localparam int DRAIN_CNT_W      = 8;
  localparam int DRAIN_OBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_obuf.sv
// Small synchronous output FIFO with a zero-latency head word.
module drain_obuf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DRAIN_DATA_W,
  parameter int DEPTH  = DRAIN_OBUF_DEPTH,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_push  = push && (occ_q != OCC_W'(DEPTH));
    do_pop   = pop && (occ_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ   = occ_q;
  assign valid = (occ_q != '0);
  assign data  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Pops a programmed burst from FIFObuffer and streams it out on valid/ready.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W     = DRAIN_DATA_W,
  parameter int CNT_W      = DRAIN_CNT_W,
  parameter int OBUF_DEPTH = DRAIN_OBUF_DEPTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_left,
  output logic              fifo_en,
  output logic              fifo_rd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a word transfers on any cycle where m_valid & m_ready;
  // once m_valid is high it stays high with m_data stable until that happens.

  localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] issue_left_q, issue_left_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic             inflight_q, inflight_d;
  logic             fifo_en_q;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;
  logic             credit_ok;
  logic             handshake;
  logic             rd;

  always_comb begin
    // Buffered words plus the read still in flight must leave room for one more.
    pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    credit_ok = (pending < (OCC_W + 1)'(OBUF_DEPTH));
    rd        = (state_q == ST_RUN) && (issue_left_q != '0) && !fifo_empty && credit_ok;
    handshake = m_valid && m_ready;

    issue_left_d = issue_left_q;
    if (rd) issue_left_d = issue_left_q - 1'b1;

    words_left_d = words_left_q;
    if (handshake && (words_left_q != '0)) words_left_d = words_left_q - 1'b1;

    inflight_d = rd;
    state_d    = state_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d      = ST_RUN;
            issue_left_d = burst_len;
            words_left_d = burst_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (issue_left_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (words_left_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      issue_left_q <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      fifo_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      fifo_en_q    <= 1'b1;
    end
  end

  drain_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_DEPTH),
    .OCC_W  (OCC_W)
  ) u_obuf (
    .clk       (Clk),
    .rst       (Rst),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (handshake),
    .occ       (occ),
    .data      (m_data),
    .valid     (m_valid)
  );

  assign fifo_rd    = rd;
  assign fifo_en    = fifo_en_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign words_left = words_left_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a FIFObuffer model and stream scoreboard.
module tb_fifo_drain_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  burst_len = '0;
  logic              busy, done, fifo_en, fifo_rd, m_valid;
  logic [CNT_W-1:0]  words_left;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] wr_q[$];
  logic              flush = 1'b0;
  int                rd_count = 0;
  int                done_cnt = 0;
  int                total = 0;
  int                bad = 0;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  fifo_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .OBUF_DEPTH(4)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .words_left (words_left),
    .fifo_en    (fifo_en),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFObuffer model: pop on fifo_rd with data one cycle later; writes land at the edge.
  always @(posedge clk) begin
    if (fifo_rd) begin
      check("rd_on_empty", (fifo_q.size() != 0), 1'b1);
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      rd_count <= rd_count + 1;
    end
    if (flush) fifo_q.delete();
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Stream monitor: order against exp_q, and stability while stalled.
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("extra_word", m_data, 64'hdead_0000_0000);
      else check("order", m_data, exp_q.pop_front());
    end
    hold_prev = m_valid && !m_ready && !rst;
    prev_data = m_data;
    if (done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic load(input logic [DATA_W-1:0] base, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(base + DATA_W'(i));
      if (expect_out) exp_q.push_back(base + DATA_W'(i));
    end
  endtask

  task automatic kick(input logic [CNT_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int rd_base;
    int done_base;

    // Reset values
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_fifo_en", fifo_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_words_left", words_left, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    check("fifo_en_after_rst", fifo_en, 1);

    // 1: five-word burst, exact cycle timing
    load(32'h0, 5, 1'b1);
    tick();
    kick(8'd5);
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("t1_rd_c%0d", c), fifo_rd, (c >= 1 && c <= 5));
      check($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 7));
      if (c >= 3 && c <= 7) check($sformatf("t1_data_c%0d", c), m_data, c - 3);
      check($sformatf("t1_wl_c%0d", c), words_left, (c <= 3) ? 5 : ((c <= 8) ? 8 - c : 0));
      check($sformatf("t1_done_c%0d", c), done, (c == 8));
      check($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 7));
      tick();
    end
    check("t1_exp_empty", exp_q.size(), 0);
    do_flush();

    // 2: back-pressure with 10 words queued, burst of 8
    load(32'h100, 8, 1'b1);
    load(32'h108, 2, 1'b0);
    m_ready = 1'b0;
    tick();
    rd_base = rd_count;
    kick(8'd8);
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    check("t2_first_valid", m_valid, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_stall_data_%0d", k), m_data, 32'h100);
      tick();
    end
    check("t2_reads_while_stalled", rd_count - rd_base, 4);
    m_ready = 1'b1;
    wait_done(30, "t2_done");
    check("t2_exp_empty", exp_q.size(), 0);
    check("t2_total_reads", rd_count - rd_base, 8);
    do_flush();

    // 3: FIFO runs dry mid-burst, refilled later
    load(32'h200, 2, 1'b1);
    tick();
    kick(8'd4);
    for (int i = 0; i < 7; i++) tick();
    check("t3_busy_starved", busy, 1);
    check("t3_wl_starved", words_left, 2);
    check("t3_rd_starved", fifo_rd, 0);
    check("t3_state_run", dbg_state, 1);
    load(32'hA, 2, 1'b1);
    wait_done(20, "t3_done");
    check("t3_exp_empty", exp_q.size(), 0);
    do_flush();

    // 4: zero-length burst with words available in the FIFO
    load(32'h700, 3, 1'b0);
    tick();
    rd_base = rd_count;
    kick(8'd0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", m_valid, 0);
    tick();
    check("t4_done_gone", done, 0);
    check("t4_busy2", busy, 0);
    check("t4_no_reads", rd_count - rd_base, 0);
    do_flush();

    // 5: reset in cycle 4 of a five-word burst
    load(32'h50, 5, 1'b0);
    exp_q.push_back(32'h50);
    exp_q.push_back(32'h51);
    tick();
    done_base = done_cnt;
    kick(8'd5);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", m_valid, 0);
    check("t5_rd", fifo_rd, 0);
    check("t5_wl", words_left, 0);
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_done", done_cnt - done_base, 0);
    check("t5_exp_empty", exp_q.size(), 0);
    do_flush();
    load(32'h60, 3, 1'b1);
    tick();
    kick(8'd3);
    wait_done(20, "t5_restart_done");
    check("t5_restart_exp_empty", exp_q.size(), 0);
    do_flush();

    // 6: second start while busy is ignored
    load(32'h80, 4, 1'b1);
    tick();
    done_base = done_cnt;
    kick(8'd4);
    tick();
    start     = 1'b1;
    burst_len = 8'd9;
    tick();
    start = 1'b0;
    check("t6_wl_unchanged", words_left, 4);
    check("t6_busy", busy, 1);
    for (int i = 0; i < 14; i++) tick();
    check("t6_one_done", done_cnt - done_base, 1);
    check("t6_idle", busy, 0);
    check("t6_exp_empty", exp_q.size(), 0);
    check("t6_wl_zero", words_left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
